// File: rtl/iob_clint_pkg.sv
// Shared CLINT address map and ticker state encoding.
package iob_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_HI0,
        ST_RD_LO,
        ST_RD_HI1,
        ST_WR_LO_MAX,
        ST_WR_HI,
        ST_WR_LO,
        ST_WAIT_IRQ,
        ST_TICK,
        ST_DISARM
    } ticker_state_t;

    // Byte address of the low (hi=0) or high (hi=1) word of a hart's mtimecmp.
    function automatic logic [15:0] mtimecmp_addr(input int unsigned hart, input logic hi);
        logic [15:0] base;
        base = MTIMECMP_BASE + 16'(hart * 8);
        return hi ? base + 16'h4 : base;
    endfunction

    // States that own a bus access.
    function automatic logic is_bus_state(input ticker_state_t s);
        return (s == ST_RD_HI0) || (s == ST_RD_LO) || (s == ST_RD_HI1) ||
               (s == ST_WR_LO_MAX) || (s == ST_WR_HI) || (s == ST_WR_LO) ||
               (s == ST_DISARM);
    endfunction

endpackage

// File: rtl/iob_clint_ticker_if.sv
// Native IOb bus bundle between the ticker (master) and the CLINT (slave).
interface iob_clint_ticker_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_clint_bus_issue.sv
// One-shot bus access: valid for a single cycle, request held until ready,
// then a registered done pulse with the captured read data.
module iob_clint_bus_issue #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                wr_i,
    output logic                valid_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ready_i,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                busy_o
);

    logic                valid_q;
    logic                pend_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   rdata_q;

    // Launch on start, then wait for ready; ready during the valid cycle is not a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (start_i && !pend_q) begin
                valid_q <= 1'b1;
                pend_q  <= 1'b1;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wstrb_q <= wr_i ? '1 : '0;
            end else if (pend_q && !valid_q && ready_i) begin
                pend_q  <= 1'b0;
                done_q  <= 1'b1;
                rdata_q <= rdata_i;
            end
        end
    end

    assign valid_o   = valid_q;
    assign address_o = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign busy_o    = pend_q;

endmodule

// File: rtl/iob_clint_ticker.sv
// Periodic tick generator that programs a CLINT mtimecmp and waits for mtip.
//
// state        | meaning
// IDLE         | disarmed, no traffic
// RD_HI0       | read mtime high word (first sample)
// RD_LO        | read mtime low word
// RD_HI1       | re-read mtime high word, restart on mismatch
// WR_LO_MAX    | park mtimecmp low at all ones while high is updated
// WR_HI        | write target high word
// WR_LO        | write target low word
// WAIT_IRQ     | armed, waiting for mtip
// TICK         | one-cycle tick, advance target by period
// DISARM       | write mtimecmp high to all ones, then IDLE
module iob_clint_ticker
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int HART   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [31:0]          period,
    input  logic                 mtip_i,
    iob_clint_ticker_if.master   bus,
    output logic                 tick,
    output logic [31:0]          tick_count,
    output logic                 busy
);

    localparam logic [15:0] CMP_LO   = mtimecmp_addr(HART, 1'b0);
    localparam logic [15:0] CMP_HI   = mtimecmp_addr(HART, 1'b1);
    localparam logic [15:0] MTIME_HI = MTIME_BASE + 16'h4;

    ticker_state_t     state_q;
    logic [63:0]       target_q;
    logic [31:0]       hi0_q;
    logic [31:0]       lo_q;
    logic [31:0]       tick_count_q;
    logic              issued_q;
    logic              en_q;

    logic              start;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wr;
    logic              bus_done;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_pend;
    logic [31:0]       rd_word;

    // DISARM must go out even with en low; every other access needs en.
    assign start   = is_bus_state(state_q) && !issued_q && !bus_pend &&
                     (en || (state_q == ST_DISARM));
    assign rd_word = 32'(bus_rdata);

    // Request address/data for the access owned by the current state.
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wr    = 1'b0;
        case (state_q)
            ST_RD_HI0, ST_RD_HI1: req_addr = ADDR_W'(MTIME_HI);
            ST_RD_LO:             req_addr = ADDR_W'(MTIME_BASE);
            ST_WR_LO_MAX: begin
                req_addr  = ADDR_W'(CMP_LO);
                req_wdata = '1;
                req_wr    = 1'b1;
            end
            ST_WR_HI: begin
                req_addr  = ADDR_W'(CMP_HI);
                req_wdata = DATA_W'(target_q[63:32]);
                req_wr    = 1'b1;
            end
            ST_WR_LO: begin
                req_addr  = ADDR_W'(CMP_LO);
                req_wdata = DATA_W'(target_q[31:0]);
                req_wr    = 1'b1;
            end
            ST_DISARM: begin
                req_addr  = ADDR_W'(CMP_HI);
                req_wdata = '1;
                req_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    iob_clint_bus_issue #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_issue (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .addr_i    (req_addr),
        .wdata_i   (req_wdata),
        .wr_i      (req_wr),
        .valid_o   (bus.valid),
        .address_o (bus.address),
        .wdata_o   (bus.wdata),
        .wstrb_o   (bus.wstrb),
        .rdata_i   (bus.rdata),
        .ready_i   (bus.ready),
        .done_o    (bus_done),
        .rdata_o   (bus_rdata),
        .busy_o    (bus_pend)
    );

    // Sequencer: read mtime safely, arm mtimecmp, tick, re-arm drift-free, disarm on en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            hi0_q        <= '0;
            lo_q         <= '0;
            tick_count_q <= '0;
            issued_q     <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            en_q <= en;
            case (state_q)
                ST_IDLE: begin
                    if (en && (period != '0)) begin
                        state_q <= ST_RD_HI0;
                    end else if (en_q && !en) begin
                        state_q <= ST_DISARM;
                    end
                end
                ST_WAIT_IRQ: begin
                    if (!en) begin
                        state_q <= ST_DISARM;
                    end else if (mtip_i) begin
                        state_q      <= ST_TICK;
                        tick_count_q <= tick_count_q + 32'd1;
                    end
                end
                ST_TICK: begin
                    if (!en) begin
                        state_q <= ST_DISARM;
                    end else begin
                        target_q <= target_q + {32'd0, period};
                        state_q  <= ST_WR_LO_MAX;
                    end
                end
                default: begin
                    if (bus_done) begin
                        issued_q <= 1'b0;
                        if (!en && (state_q != ST_DISARM)) begin
                            state_q <= ST_DISARM;
                        end else begin
                            case (state_q)
                                ST_RD_HI0: begin
                                    hi0_q   <= rd_word;
                                    state_q <= ST_RD_LO;
                                end
                                ST_RD_LO: begin
                                    lo_q    <= rd_word;
                                    state_q <= ST_RD_HI1;
                                end
                                ST_RD_HI1: begin
                                    if (rd_word != hi0_q) begin
                                        state_q <= ST_RD_HI0;
                                    end else begin
                                        target_q <= {hi0_q, lo_q} + {32'd0, period};
                                        state_q  <= ST_WR_LO_MAX;
                                    end
                                end
                                ST_WR_LO_MAX: state_q <= ST_WR_HI;
                                ST_WR_HI:     state_q <= ST_WR_LO;
                                ST_WR_LO:     state_q <= ST_WAIT_IRQ;
                                default:      state_q <= ST_IDLE;
                            endcase
                        end
                    end else if (!issued_q) begin
                        if (start) begin
                            issued_q <= 1'b1;
                        end else if (!bus_pend) begin
                            state_q <= ST_DISARM;
                        end
                    end
                end
            endcase
        end
    end

    assign tick       = (state_q == ST_TICK);
    assign busy       = (state_q != ST_IDLE);
    assign tick_count = tick_count_q;

endmodule

// File: doc/iob_clint_ticker.md
IOB_CLINT_TICKER -- requirements
Module: iob_clint_ticker

Interface
REQ-001 Parameter ADDR_W, 16, bus address width.
REQ-002 Parameter DATA_W, 32, bus data width; only 32 is supported.
REQ-003 Parameter HART, 0, index of the mtimecmp register this block programs.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  level; 1 = run periodic ticks, 0 = stop and disarm.
REQ-007 period  in  32  tick interval in mtime units, zero-extended to 64 bits.
REQ-008 mtip_i  in  1  machine timer interrupt for HART from the timer device, same clock domain.
REQ-009 valid  out  1  bus request, initiator side of the native IOb bus.
REQ-010 address  out  ADDR_W  byte address of the access.
REQ-011 wdata  out  DATA_W  write data.
REQ-012 wstrb  out  DATA_W/8  write strobes; all ones = write, zero = read.
REQ-013 rdata  in  DATA_W  read data, valid in the cycle ready=1.
REQ-014 ready  in  1  access completion, one or more cycles after valid.
REQ-015 tick  out  1  one-cycle pulse per expired period.
REQ-016 tick_count  out  32  number of ticks since reset, wraps at 2^32.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 Each access SHALL drive valid=1 for exactly one cycle, then hold valid=0 with address/wdata/wstrb stable until ready=1; the next access SHALL NOT issue before that ready.
REQ-019 Fixed address map: mtime lo 0xBFF8, mtime hi 0xBFFC, mtimecmp lo 0x4000+8*HART, mtimecmp hi 0x4004+8*HART.
REQ-020 States: IDLE, RD_HI0, RD_LO, RD_HI1, WR_LO_MAX, WR_HI, WR_LO, WAIT_IRQ, TICK, DISARM.
REQ-021 IDLE -> RD_HI0 when en=1 and period!=0; with period=0 the block SHALL stay in IDLE with no bus traffic.
REQ-022 RD_HI0 -> RD_LO -> RD_HI1 reads mtime; if the RD_HI1 value differs from RD_HI0, the sequence SHALL restart at RD_HI0 (rollover-safe read).
REQ-023 On a consistent read: target = {hi,lo} + period, 64-bit, wrapping modulo 2^64.
REQ-024 Arming writes, in order: mtimecmp lo=0xFFFFFFFF, mtimecmp hi=target[63:32], mtimecmp lo=target[31:0]; then WAIT_IRQ.
REQ-025 WAIT_IRQ -> TICK when mtip_i=1; TICK lasts one cycle with tick=1 and tick_count+1.
REQ-026 TICK -> WR_LO_MAX with target = target + period (period sampled in TICK), keeping ticks drift-free without re-reading mtime.
REQ-027 If target is already passed at arming, mtip_i is high on entry to WAIT_IRQ and TICK SHALL follow in the next cycle; no tick is skipped or merged.
REQ-028 en=0 in any state: an outstanding access SHALL complete first; then DISARM writes mtimecmp hi=0xFFFFFFFF and returns to IDLE; from IDLE or WAIT_IRQ DISARM starts in the next cycle.
REQ-029 en=0 and mtip_i=1 in the same WAIT_IRQ cycle: en takes priority and no tick is emitted.
REQ-030 period changes take effect only at the next target computation.

Reset
REQ-031 While rst_n=0: state IDLE, valid=0, wstrb=0, address=0, wdata=0, tick=0, tick_count=0, busy=0, target=0.
REQ-032 Reset asserted mid-access SHALL abandon the access; the first access after reset SHALL be RD_HI0.

Structure
REQ-033 Shared package iob_clint_pkg holds the CLINT address-map constants (MSIP_BASE, MTIMECMP_BASE, MTIME_BASE) and the state encoding.
REQ-034 One sub-module, iob_clint_bus_issue, implements the REQ-018 one-shot issue/wait handshake and returns done plus captured rdata.

Verification
REQ-035 mtime=0x0000_0000_0000_0100 and period=0x50 with en=1 -> reads then writes lo=FFFFFFFF, hi=0, lo=0x150; the first tick occurs when mtime reaches 0x150.
REQ-036 mtime=0x0000_0000_FFFF_FFFF, with hi incrementing between the two hi reads -> read sequence restarts and target = 0x1_0000_0000 + period.
REQ-037 period=10 for 5 ticks -> mtimecmp lo writes t0+10 … t0+50 and tick_count=5.
REQ-038 Responder with ready latency of 1, 3 and 7 cycles -> valid stays high exactly one cycle per access, and the access sequence and values are identical across latencies.
REQ-039 en dropped during WR_HI wait -> WR_HI completes, mtimecmp hi=0xFFFFFFFF is written, state returns to IDLE, and no tick occurs.
REQ-040 period=0 with en=1, and rst_n pulsed during RD_LO -> no bus traffic while period=0; after reset, all outputs take their REQ-031 values.
